// File: rtl/tx_pulse_ch_pkg.sv
// Shared widths, FSM state encoding and output decode for the transmit pulser.
// The sequencer at array level reuses the same state encoding.
package tx_pulse_ch_pkg;

  localparam int DEF_ADDR_WD = 7;
  localparam int DEF_DLY_WD  = 12;
  localparam int DEF_CYC_WD  = 4;
  localparam int DEF_HALF_WD = 6;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_DELAY   = 3'd2,
    S_PULSE_P = 3'd3,
    S_PULSE_N = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  typedef struct packed {
    logic p;
    logic n;
    logic tx;
    logic busy;
    logic done;
  } out_t;

  // Outputs are registered from the next state, so they track the state exactly.
  function automatic out_t outs(state_t s);
    out_t o;
    o.p    = (s == S_PULSE_P);
    o.n    = (s == S_PULSE_N);
    o.tx   = (s == S_LOAD) || (s == S_DELAY) || (s == S_PULSE_P) || (s == S_PULSE_N);
    o.busy = (s != S_IDLE);
    o.done = (s == S_DONE);
    return o;
  endfunction

endpackage

// File: rtl/tx_dly_lut.sv
// Per-beam transmit delay table: simple dual-port RAM, synchronous write,
// registered synchronous read (read-before-write on an address collision).
module tx_dly_lut #(
  parameter int AW = 7,
  parameter int DW = 12
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [2**AW];
  logic [DW-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/tx_pulse_ch.sv
// Per-channel transmit pulser: delay-LUT lookup on fire, wait D clocks,
// then N bipolar cycles of half-period H on pulse_p / pulse_n.
module tx_pulse_ch
  import tx_pulse_ch_pkg::*;
#(
  parameter int ADDR_WD = DEF_ADDR_WD,
  parameter int DLY_WD  = DEF_DLY_WD,
  parameter int CYC_WD  = DEF_CYC_WD,
  parameter int HALF_WD = DEF_HALF_WD
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_WD-1:0] lut_addr,
  input  logic [DLY_WD-1:0]  lut_din,
  input  logic               lut_we,
  input  logic [ADDR_WD-1:0] beam_sel,
  input  logic               fire,
  input  logic [CYC_WD-1:0]  n_cycles,
  input  logic [HALF_WD-1:0] half_period,
  output logic               pulse_p,
  output logic               pulse_n,
  output logic               tx_en,
  output logic               busy,
  output logic               done
);

  state_t             r_state;
  out_t               r_out;
  logic [DLY_WD-1:0]  r_dly;
  logic [HALF_WD-1:0] r_half;
  logic [HALF_WD-1:0] r_hcnt;
  logic [CYC_WD-1:0]  r_ncyc;
  logic [DLY_WD-1:0]  w_lut_q;
  logic               w_rd_en;

  // Read only on an accepted fire so the LOAD state sees this event's delay.
  assign w_rd_en = fire && (r_state == S_IDLE) && !rst;

  tx_dly_lut #(.AW(ADDR_WD), .DW(DLY_WD)) u_lut (
    .clk     (clk),
    .i_we    (lut_we),
    .i_waddr (lut_addr),
    .i_wdata (lut_din),
    .i_re    (w_rd_en),
    .i_raddr (beam_sel),
    .o_rdata (w_lut_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_out   <= '0;
      r_dly   <= '0;
      r_half  <= '0;
      r_hcnt  <= '0;
      r_ncyc  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (fire) begin
          r_state <= S_LOAD;
          r_out   <= outs(S_LOAD);
          r_ncyc  <= n_cycles;
          r_half  <= (half_period == '0) ? HALF_WD'(1) : half_period;
        end
        S_LOAD: begin
          r_dly   <= w_lut_q;
          r_state <= S_DELAY;
          r_out   <= outs(S_DELAY);
        end
        S_DELAY: begin
          if (r_dly == '0) begin
            if (r_ncyc == '0) begin
              r_state <= S_DONE;
              r_out   <= outs(S_DONE);
            end else begin
              r_state <= S_PULSE_P;
              r_out   <= outs(S_PULSE_P);
              r_hcnt  <= r_half - HALF_WD'(1);
              r_ncyc  <= r_ncyc - CYC_WD'(1);
            end
          end else begin
            r_dly <= r_dly - DLY_WD'(1);
          end
        end
        S_PULSE_P: begin
          if (r_hcnt == '0) begin
            r_state <= S_PULSE_N;
            r_out   <= outs(S_PULSE_N);
            r_hcnt  <= r_half - HALF_WD'(1);
          end else begin
            r_hcnt <= r_hcnt - HALF_WD'(1);
          end
        end
        S_PULSE_N: begin
          // r_ncyc counts cycles still to start after the current one.
          if (r_hcnt == '0) begin
            if (r_ncyc != '0) begin
              r_state <= S_PULSE_P;
              r_out   <= outs(S_PULSE_P);
              r_hcnt  <= r_half - HALF_WD'(1);
              r_ncyc  <= r_ncyc - CYC_WD'(1);
            end else begin
              r_state <= S_DONE;
              r_out   <= outs(S_DONE);
            end
          end else begin
            r_hcnt <= r_hcnt - HALF_WD'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_out   <= outs(S_IDLE);
        end
        default: begin
          r_state <= S_IDLE;
          r_out   <= '0;
        end
      endcase
    end
  end

  assign pulse_p = r_out.p;
  assign pulse_n = r_out.n;
  assign tx_en   = r_out.tx;
  assign busy    = r_out.busy;
  assign done    = r_out.done;

endmodule
